// File: rtl/game_master_link.sv
// game_master_link: master-side link engine for the two-board game.
// RX: accepts 1-byte P2 button packets, supervises the link with a timeout.
// TX: on each frame tick snapshots game state and HP and sends a 3-byte
// state frame {state,1,seq} / p1_hp / p2_hp through the UART TX handshake.
module game_master_link #(
  parameter int LINK_TIMEOUT = 5000000,
  parameter int TO_W         = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [2:0] game_state_in,
  input  logic [7:0] p1_hp_in,
  input  logic [7:0] p2_hp_in,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [3:0] p2_ctrl,
  output logic       link_up,
  output logic [7:0] rx_err_cnt,
  output logic [3:0] frame_seq
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(LINK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} tx_state_t;

  // Error counter sticks at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---------------- RX path ----------------
  logic [TO_W-1:0] to_cnt;
  logic            rx_accept;

  assign rx_accept = rx_valid && (rx_data[7:4] == 4'h0);

  // Packet accept / reject and link supervision; accept beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_ctrl    <= 4'h0;
      link_up    <= 1'b0;
      rx_err_cnt <= 8'h00;
      to_cnt     <= '0;
    end else if (rx_accept) begin
      p2_ctrl <= rx_data[3:0];
      link_up <= 1'b1;
      to_cnt  <= '0;
    end else if (rx_valid) begin
      rx_err_cnt <= sat_inc8(rx_err_cnt);
    end else if (to_cnt == TO_MAX) begin
      link_up <= 1'b0;
      p2_ctrl <= 4'h0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // ---------------- TX path ----------------
  tx_state_t  state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] seq, seq_nxt;
  logic       pending, pending_nxt;
  logic [2:0] snap_state, snap_state_nxt;
  logic [7:0] snap_p1, snap_p1_nxt;
  logic [7:0] snap_p2, snap_p2_nxt;
  logic [7:0] tx_data_nxt;
  logic       tx_start_nxt;
  logic [7:0] cur_byte;

  assign frame_seq = seq;

  // Select the frame byte for the current index from the snapshot.
  always_comb begin
    cur_byte = snap_p2;
    case (idx)
      2'd0:    cur_byte = {snap_state, 1'b1, seq};
      2'd1:    cur_byte = snap_p1;
      default: cur_byte = snap_p2;
    endcase
  end

  // Frame sequencing: next state, snapshot capture, one tx_start per byte.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    seq_nxt        = seq;
    pending_nxt    = pending;
    snap_state_nxt = snap_state;
    snap_p1_nxt    = snap_p1;
    snap_p2_nxt    = snap_p2;
    tx_data_nxt    = tx_data;
    tx_start_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick || pending) begin
          snap_state_nxt = game_state_in;
          snap_p1_nxt    = p1_hp_in;
          snap_p2_nxt    = p2_hp_in;
          seq_nxt        = seq + 4'd1;
          pending_nxt    = 1'b0;
          idx_nxt        = 2'd0;
          state_nxt      = LOAD;
        end
      end
      LOAD: begin
        if (!tx_busy) begin
          tx_data_nxt  = cur_byte;
          tx_start_nxt = 1'b1;
          state_nxt    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == 2'd2) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Ticks that land mid-frame coalesce into a single deferred frame.
    if (state != IDLE && frame_tick) pending_nxt = 1'b1;
  end

  // TX state and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      seq        <= 4'h0;
      pending    <= 1'b0;
      snap_state <= 3'd0;
      snap_p1    <= 8'h00;
      snap_p2    <= 8'h00;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      seq        <= seq_nxt;
      pending    <= pending_nxt;
      snap_state <= snap_state_nxt;
      snap_p1    <= snap_p1_nxt;
      snap_p2    <= snap_p2_nxt;
      tx_data    <= tx_data_nxt;
      tx_start   <= tx_start_nxt;
    end
  end

endmodule

// File: doc/game_master_link.md
Name: game_master_link

Overview:
- Master-side link engine for the two-board game.
- Receives the mirror board's 1-byte button packets on the UART RX path and presents them to game logic as a debounced-by-protocol P2 control with link supervision.
- On every frame tick it snapshots authoritative game state and both HP values, then sends a 3-byte state frame to the mirror through the UART TX handshake.
- Sits between the UART RX/TX cores and the master game FSM.

Parameters:
- LINK_TIMEOUT, 5000000: clk cycles without a valid RX packet before the link is declared down (0.1 s at 50 MHz).
- TO_W, 23: width of the timeout counter; must satisfy 2^TO_W > LINK_TIMEOUT.

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- frame_tick  input  1  one-cycle pulse per game frame (60 Hz)
- game_state_in  input  3  current master game state
- p1_hp_in  input  8  P1 hit points
- p2_hp_in  input  8  P2 hit points
- rx_data  input  8  byte from UART RX
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- tx_busy  input  1  UART TX busy; high from the cycle after tx_start until the stop bit completes
- tx_data  output  8  byte to transmit; stable while tx_start is high
- tx_start  output  1  one-cycle transmit request
- p2_ctrl  output  4  latest accepted P2 buttons
- link_up  output  1  high while valid packets arrive within LINK_TIMEOUT
- rx_err_cnt  output  8  saturating count of rejected RX bytes
- frame_seq  output  4  sequence number of the last frame started

Behaviour:

Reset (async, rst_n low):
- All outputs are 0, TX FSM is in IDLE, pending is 0, timeout counter is 0, snapshot registers are 0.
- Reset asserted mid-frame aborts the frame immediately; no further tx_start is issued.

RX path:
- A byte is accepted when rx_valid=1 and rx_data[7:4]==4'h0.
- On accept, the next cycle has p2_ctrl=rx_data[3:0] and link_up=1, and the timeout counter clears to 0.
- A byte with rx_valid=1 and a nonzero upper nibble is rejected:
  - rx_err_cnt increments, saturating at 255.
  - p2_ctrl, link_up and the timeout counter are unchanged.
- With no accepted byte, the timeout counter increments each cycle and saturates at LINK_TIMEOUT.
- When the count reaches LINK_TIMEOUT, the next cycle has link_up=0 and p2_ctrl=4'h0, which forces neutral input on link loss.
- An accept in the same cycle the timeout is reached wins: the link stays up.

TX frame format (3 bytes, in order):
- B0 = {snap_state[2:0], 1'b1, seq[3:0]}
- B1 = snap_p1_hp
- B2 = snap_p2_hp

Snapshot and sequence:
- Snapshot registers are loaded in the cycle the frame starts.
- seq increments mod 16 at each frame start (wraps 15->0) and is mirrored on frame_seq.

TX FSM states: IDLE, LOAD, WAIT_HI, WAIT_LO, with byte index idx 0..2.
- IDLE:
  - On frame_tick or pending: capture the snapshot, increment seq, clear pending, set idx=0, go to LOAD.
- LOAD:
  - If tx_busy=0: drive tx_data = byte[idx] and tx_start=1 for exactly one cycle, then go to WAIT_HI.
  - Otherwise hold in LOAD with tx_start=0.
- WAIT_HI:
  - Wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO:
  - Wait for tx_busy=0.
  - If idx==2, go to IDLE; otherwise increment idx and go to LOAD.
- Exactly one tx_start is issued per byte. tx_data holds its value after tx_start until the next LOAD.

Ticks during a frame:
- A frame_tick arriving outside IDLE sets pending=1; multiple ticks coalesce into one.
- The pending frame starts on the cycle after returning to IDLE, using values sampled at its start, not at the tick.
- A frame_tick in the same cycle IDLE sees pending starts only one frame and clears pending.

Timing:
- Latency from frame_tick in IDLE to the first tx_start is 2 cycles when tx_busy=0 (IDLE->LOAD, LOAD drives tx_start).
- The RX and TX paths are independent; simultaneous rx_valid and TX activity are both serviced.

Test Plan:
- Reset, then rx_valid with rx_data=8'h05 -> next cycle p2_ctrl=4'h5 and link_up=1; then rx_data=8'hA3 -> p2_ctrl stays 5 and rx_err_cnt=1.
- State=3'b010, p1_hp=100, p2_hp=37, frame_tick, tx_busy model 10 cycles per byte -> tx_start bytes are 8'h51, 8'h64, 8'h25 (seq=1), one tx_start each, frame_seq=1.
- Two frame_ticks during an in-flight frame with hp changed to 90 before the frame ends -> exactly one extra frame follows with B1=8'h5A and seq=2.
- Accept one packet, then LINK_TIMEOUT=100 with no traffic -> link_up falls and p2_ctrl=0 on cycle 101 after the accept; a new packet restores link_up.
- Send 300 bad bytes -> rx_err_cnt saturates at 255; send 17 frames -> frame_seq wraps and B0 low nibble goes 15 -> 0.
- Assert rst_n low after B1 tx_start -> outputs are 0 immediately and no B2 is sent after reset release.
